// File: rtl/video_pattern_generator.sv
// Video timing and test-pattern source: free-running h/v raster counters,
// frame-boundary shadowing of the pattern controls, and registered HS/VS/DE/RGB.
module video_pattern_generator #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int COLOR_BITS = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int RAMP_SHIFT = 2,
  parameter int BAR_W      = 16,
  parameter int BAR_STEP   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [2:0]            i_mode,
  input  logic [COLOR_BITS-1:0] i_solid_r,
  input  logic [COLOR_BITS-1:0] i_solid_g,
  input  logic [COLOR_BITS-1:0] i_solid_b,
  output logic                  o_hs,
  output logic                  o_vs,
  output logic                  o_de,
  output logic [COLOR_BITS-1:0] o_r,
  output logic [COLOR_BITS-1:0] o_g,
  output logic [COLOR_BITS-1:0] o_b,
  output logic                  o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW:0]   H_ACT_E    = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   BAR_STEP_E = (HW+1)'(BAR_STEP);
  localparam logic [HW:0]   BAR_W_E    = (HW+1)'(BAR_W);

  logic [HW-1:0]         r_h;
  logic [VW-1:0]         r_v;
  logic [7:0]            r_frame;
  logic [HW-1:0]         r_bar_start;
  logic [2:0]            r_mode;
  logic [COLOR_BITS-1:0] r_solid_r, r_solid_g, r_solid_b;

  logic                  w_frame_end;
  logic                  w_de, w_hs_act, w_vs_act;
  logic [6:0]            w_bar_ge;
  logic [2:0]            w_bar_idx;
  logic [HW:0]           w_bar_sum, w_bar_dist;
  logic [HW-1:0]         w_bar_start_next;
  logic                  w_full;
  logic [COLOR_BITS-1:0] w_r, w_g, w_b;

  assign w_frame_end = (r_h == H_LAST) && (r_v == V_LAST);
  assign w_de        = (r_h < H_ACT_C) && (r_v < V_ACT_C);
  assign w_hs_act    = (r_h >= HS_START) && (r_h < HS_END);
  assign w_vs_act    = (r_v >= VS_START) && (r_v < VS_END);

  // Colour-bar boundaries are elaboration constants; the comparisons are
  // monotonic in x, so the number of boundaries passed is the bar index.
  for (genvar gi = 0; gi < 7; gi++) begin : g_bar_bound
    assign w_bar_ge[gi] = (r_h >= HW'(H_ACTIVE * (gi + 1) / 8));
  end
  assign w_bar_idx = 3'($countones(w_bar_ge));

  // Bar start advances by BAR_STEP mod H_ACTIVE each frame; it restarts at 0
  // when the 8-bit frame counter wraps so it always equals (f*BAR_STEP) mod H_ACTIVE.
  assign w_bar_sum        = {1'b0, r_bar_start} + BAR_STEP_E;
  assign w_bar_start_next = (r_frame == 8'hFF) ? '0 :
                            (w_bar_sum >= H_ACT_E) ? HW'(w_bar_sum - H_ACT_E) : HW'(w_bar_sum);
  assign w_bar_dist       = (r_h >= r_bar_start) ? ({1'b0, r_h} - {1'b0, r_bar_start})
                                                 : ({1'b0, r_h} + H_ACT_E - {1'b0, r_bar_start});

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Pattern controls shadowed at the last clock of the frame so a frame never tears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode      <= 3'd1;
      r_solid_r   <= '0;
      r_solid_g   <= '0;
      r_solid_b   <= '0;
      r_frame     <= '0;
      r_bar_start <= '0;
    end else if (w_frame_end) begin
      r_mode      <= i_mode;
      r_solid_r   <= i_solid_r;
      r_solid_g   <= i_solid_g;
      r_solid_b   <= i_solid_b;
      r_frame     <= r_frame + 1'b1;
      r_bar_start <= w_bar_start_next;
    end
  end

  // Pixel colour for the current counter position under the shadowed mode.
  always_comb begin
    w_r    = '0;
    w_g    = '0;
    w_b    = '0;
    w_full = 1'b0;
    case (r_mode)
      3'd0: begin
        w_r = r_solid_r;
        w_g = r_solid_g;
        w_b = r_solid_b;
      end
      3'd1: begin
        w_r = {COLOR_BITS{~w_bar_idx[1]}};
        w_g = {COLOR_BITS{~w_bar_idx[2]}};
        w_b = {COLOR_BITS{~w_bar_idx[0]}};
      end
      3'd2: begin
        w_r = COLOR_BITS'(r_h >> RAMP_SHIFT);
        w_g = w_r;
        w_b = w_r;
      end
      3'd3: w_full = r_h[CHECK_LOG2] ^ r_v[CHECK_LOG2];
      3'd4: w_full = (w_bar_dist < BAR_W_E);
      3'd5: w_full = (r_h == '0) || (r_h == H_ACT_C - 1'b1) ||
                     (r_v == '0) || (r_v == V_ACT_C - 1'b1);
      default: w_full = 1'b0;
    endcase
    if (r_mode >= 3'd3) begin
      w_r = {COLOR_BITS{w_full}};
      w_g = {COLOR_BITS{w_full}};
      w_b = {COLOR_BITS{w_full}};
    end
    if (!w_de) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
  end

  // Output register stage: everything leaves the block one clock after its counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hs          <= ~HS_POL;
      o_vs          <= ~VS_POL;
      o_de          <= 1'b0;
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_hs          <= w_hs_act ? HS_POL : ~HS_POL;
      o_vs          <= w_vs_act ? VS_POL : ~VS_POL;
      o_de          <= w_de;
      o_r           <= w_r;
      o_g           <= w_g;
      o_b           <= w_b;
      o_frame_start <= (r_h == '0) && (r_v == '0);
    end
  end

endmodule

// File: tb/tb_video_pattern_generator.sv
// Self-checking bench: small raster, randomised pattern controls changed at
// random points inside each frame, compared every clock against a frame/pixel model.
module tb_video_pattern_generator;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 24
  localparam int VT = VA + VF + VS + VB;   // 12
  localparam int FRAME = HT * VT;          // 288
  localparam int NFR = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] sr = 8'h0, sg = 8'h0, sb = 8'h0;

  logic       hs_p, vs_p, de_p, fs_p;
  logic [7:0] r_p, g_p, b_p;
  logic       hs_n, vs_n, de_n, fs_n;
  logic [7:0] r_n, g_n, b_n;

  int n_assert = 0;
  int n_fail = 0;

  // Model state
  int t;            // output edges since reset release
  int m_mode;
  logic [23:0] m_solid;
  int m_frame;

  always #5 clk = ~clk;

  video_pattern_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_BITS(8),
    .CHECK_LOG2(1), .RAMP_SHIFT(0), .BAR_W(4), .BAR_STEP(6)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode),
    .i_solid_r(sr), .i_solid_g(sg), .i_solid_b(sb),
    .o_hs(hs_p), .o_vs(vs_p), .o_de(de_p),
    .o_r(r_p), .o_g(g_p), .o_b(b_p), .o_frame_start(fs_p)
  );

  video_pattern_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_BITS(8),
    .CHECK_LOG2(1), .RAMP_SHIFT(0), .BAR_W(4), .BAR_STEP(6)
  ) u_dut_neg (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode),
    .i_solid_r(sr), .i_solid_g(sg), .i_solid_b(sb),
    .o_hs(hs_n), .o_vs(vs_n), .o_de(de_n),
    .o_r(r_n), .o_g(g_n), .o_b(b_n), .o_frame_start(fs_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // Reference colour for a pixel, straight from the pattern definitions.
  function automatic logic [23:0] model_rgb(input int x, input int y, input int md,
                                            input logic [23:0] solid, input int f);
    logic [23:0] bars [8];
    int s;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    if (!(x < HA && y < VA)) return 24'h0;
    case (md)
      0: return solid;
      1: return bars[(x * 8) / HA];
      2: return {3{8'(x)}};
      3: return ((((x / 2) + (y / 2)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
      4: begin
        s = ((f % 256) * 6) % HA;
        return (((x - s + HA) % HA) < 4) ? 24'hFFFFFF : 24'h0;
      end
      5: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_de"}, 32'(de_p), 32'd0);
    chk({tag, "_fs"}, 32'(fs_p), 32'd0);
    chk({tag, "_rgb"}, 32'({r_p, g_p, b_p}), 32'd0);
    chk({tag, "_hs"}, 32'(hs_p), 32'd0);
    chk({tag, "_vs"}, 32'(vs_p), 32'd0);
    chk({tag, "_hs_neg"}, 32'(hs_n), 32'd1);
    chk({tag, "_vs_neg"}, 32'(vs_n), 32'd1);
    chk({tag, "_de_neg"}, 32'(de_n), 32'd0);
  endtask

  task automatic model_restart();
    t = 0;
    m_mode = 1;
    m_solid = 24'h0;
    m_frame = 0;
  endtask

  // One clock: check the pixel the model predicts for this edge, then apply
  // the frame-end latch if this edge was the last clock of the frame.
  task automatic step();
    int p, x, y;
    logic hs_act, vs_act;
    logic [23:0] exp_rgb;
    @(posedge clk);
    #1;
    p = t % FRAME;
    x = p % HT;
    y = p / HT;
    hs_act = (x >= HA + HF) && (x < HA + HF + HS);
    vs_act = (y >= VA + VF) && (y < VA + VF + VS);
    exp_rgb = model_rgb(x, y, m_mode, m_solid, m_frame);
    chk("de", 32'(de_p), 32'(x < HA && y < VA));
    chk("fs", 32'(fs_p), 32'(p == 0));
    chk("hs", 32'(hs_p), 32'(hs_act));
    chk("vs", 32'(vs_p), 32'(vs_act));
    chk("rgb", 32'({r_p, g_p, b_p}), 32'(exp_rgb));
    chk("hs_neg", 32'(hs_n), 32'(!hs_act));
    chk("vs_neg", 32'(vs_n), 32'(!vs_act));
    chk("rgb_neg", 32'({r_n, g_n, b_n}), 32'(exp_rgb));
    if (p == FRAME - 1) begin
      m_mode = int'(mode);
      m_solid = {sr, sg, sb};
      m_frame = m_frame + 1;
    end
    t++;
  endtask

  // Run one frame, changing controls at two random points; only the last
  // value before the frame end should ever become visible.
  task automatic run_frame(input int final_mode);
    int c1, c2;
    c1 = $urandom_range(0, 140);
    c2 = $urandom_range(150, 280);
    $display("frame %0d: shown mode %0d, f %0d, next mode %0d", m_frame, m_mode, m_frame % 256, final_mode);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (i == c1) begin
        mode = 3'($urandom_range(0, 7));
        {sr, sg, sb} = 24'($urandom);
      end
      if (i == c2) begin
        mode = 3'(final_mode);
        {sr, sg, sb} = 24'($urandom);
      end
    end
  endtask

  initial begin
    int plan [11];
    plan = '{3, 4, 4, 4, 4, 0, 2, 5, 6, 7, 1};
    model_restart();
    mode = 3'd5;
    {sr, sg, sb} = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    for (int k = 0; k < NFR; k++)
      run_frame(k < 11 ? plan[k] : int'($urandom_range(0, 7)));

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 100; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(posedge clk);
    #1;
    chk_reset("midreset_hold");
    rst_n = 1'b1;
    model_restart();
    $display("reset mid-frame, restarting");
    for (int k = 0; k < 3; k++) run_frame(int'($urandom_range(0, 5)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/video_pattern_generator.md
# video_pattern_generator

Parametrised video timing and test-pattern source for the OLED/LCD bring-up path. Generates HS/VS/DE and RGB pixels for any raster geometry (SVGA 800x600@60 at 40 MHz by default), with six runtime-selectable patterns, configurable sync polarity and colour depth. Feeds the display serialiser directly in place of the fixed-pattern generator; pattern changes take effect only on frame boundaries so the panel never sees a torn frame.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal porch/sync lengths in clocks
- V_ACTIVE, 600, visible lines per frame
- V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porch/sync lengths in lines
- HS_POL / VS_POL, 1 / 1, active level of HS / VS
- COLOR_BITS, 8, bits per colour channel
- CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels
- RAMP_SHIFT, 2, gray ramp level = x >> RAMP_SHIFT
- BAR_W / BAR_STEP, 16 / 4, moving-bar width and per-frame advance in pixels
- Clock  in  1  pixel clock
- Reset  in  1  asynchronous, active-low reset
- Mode  in  3  pattern select, sampled at frame end
- SolidR / SolidG / SolidB  in  COLOR_BITS each  solid-fill colour, sampled with Mode
- HS / VS / DE  out  1  sync and data-enable
- R / G / B  out  COLOR_BITS each  pixel colour
- FrameStart  out  1  one-cycle pulse coincident with pixel (0,0)

## Operation
- H_TOTAL = sum of horizontal params (1056), V_TOTAL = sum of vertical (628); counters h, v sized $clog2(H_TOTAL), $clog2(V_TOTAL).
- h counts 0..H_TOTAL-1, wraps to 0; v increments on h wrap, wraps 0 after V_TOTAL-1.
- DE = (h < H_ACTIVE) && (v < V_ACTIVE); x = h, y = v inside active area.
- HS active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; VS active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines); inactive level = !POL.
- At h=H_TOTAL-1, v=V_TOTAL-1: Mode and Solid* latched into shadow registers; 8-bit frame counter f increments (wraps 255->0).
- Patterns (shadow mode), full = all ones:
  - 0 solid: Solid* shadow values
  - 1 colour bars: 8 equal bars, boundaries at H_ACTIVE*i/8 (elaboration constants): white, yellow, cyan, green, magenta, red, blue, black
  - 2 gray ramp: R=G=B = (x >> RAMP_SHIFT) truncated to COLOR_BITS (wraps)
  - 3 checker: full when x[CHECK_LOG2]^y[CHECK_LOG2], else 0
  - 4 moving bar: start s = (f*BAR_STEP) mod H_ACTIVE; full when (x - s) mod H_ACTIVE < BAR_W (wraps right edge to left), else 0
  - 5 border: full on x=0, x=H_ACTIVE-1, y=0, y=V_ACTIVE-1, else 0
  - 6, 7: black
- RGB forced 0 whenever DE=0.

## Timing
- Reset asserted (async): h=v=0, f=0, shadow mode=1 (colour bars), shadow Solid*=0; outputs DE=0, FrameStart=0, RGB=0, HS=!HS_POL, VS=!VS_POL.
- All outputs registered; one-cycle latency: output at edge n reflects counters at edge n-1.
- First rising edge after Reset release: outputs show pixel (0,0), DE=1, FrameStart=1; counters now (1,0).
- Mode change takes effect at the FrameStart pixel following the latch; mid-frame Mode/Solid* changes are invisible in the current frame.
- Reset mid-frame: immediate async return to reset values; restart as above.
- Frame = H_TOTAL*V_TOTAL = 663,168 clocks (16.579 ms at 40 MHz).

## Test plan
Small geometry for speed unless stated: H 16/2/4/2 (H_TOTAL 24), V 8/1/2/1 (V_TOTAL 12), COLOR_BITS 8.
- Reset release -> first edge DE=1, FrameStart=1, RGB=FFFFFF (bar 0 white); DE high 16 clocks per line, 8 lines; HS active clocks 18..21 of each line; VS active lines 9..10; FrameStart every 288 clocks.
- Mode=3, CHECK_LOG2=1 -> next frame pixel (0,0)=000000, (2,0)=FFFFFF, (2,2)=000000; mid-frame Mode=0 ignored until following FrameStart.
- Mode=4, BAR_W=4, BAR_STEP=6 -> frame f=2 bar at x=12..15; f=3 start 2 (18 mod 16), bar x=2..5; f=... with start 14 wraps to x=14,15,0,1.
- Mode=2, RAMP_SHIFT=0 -> R=G=B=x for x=0..15; RGB=0 during blanking.
- HS_POL=VS_POL=0 -> sync idle high, pulses low, same positions.
- Default SVGA params: HS active h 840..967, VS lines 601..604, frame 663,168 clocks; assert Reset low at v=300 -> all outputs reset values within same cycle, restart at (0,0).
